// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: shared widths, instruction encoding and helpers for the
// SimpleCPU core.
//   - opcode_e   : 4-bit opcode field of the instruction word
//   - instr_t    : opcode / rd / imm8 view of a 16-bit instruction word
//   - alu_op_e   : operation selected for the execution unit
//   - HALT_WORD  : encoding of HALT, the instruction memory fill value
package simple_cpu_pkg;

  localparam int unsigned PC_W       = 10;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned IMEM_DEPTH = 1024;
  localparam int unsigned DMEM_DEPTH = 256;
  localparam int unsigned NREGS      = 16;
  localparam int unsigned REG_AW     = 4;
  localparam int unsigned DMEM_AW    = 8;

  localparam logic [DATA_W-1:0] HALT_WORD = 16'hF000;

  typedef enum logic [3:0] {
    OP_LD    = 4'h0,
    OP_JMP   = 4'h1,
    OP_ADD   = 4'h2,
    OP_LDI   = 4'h3,
    OP_SUB   = 4'h4,
    OP_ST    = 4'h5,
    OP_BEQZ  = 4'h6,
    OP_ADDI  = 4'h7,
    OP_AND   = 4'h8,
    OP_OR    = 4'h9,
    OP_XOR   = 4'hA,
    OP_NOP_B = 4'hB,
    OP_NOP_C = 4'hC,
    OP_NOP_D = 4'hD,
    OP_NOP_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [3:0]  rd;
    logic [7:0]  imm8;
  } instr_t;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5
  } alu_op_e;

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/simple_cpu_dmem.sv
// simple_cpu_dmem: 256x16 data memory, no reset, no initial contents.
//   clk   : write clock
//   we    : write enable (already qualified by the core)
//   addr  : word address
//   wdata : write data
//   rdata : combinational read data
module simple_cpu_dmem
  import simple_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem_array [0:DMEM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
  end

  assign rdata = mem_array[addr];

endmodule

// File: rtl/simple_cpu_execunit.sv
// simple_cpu_execunit: register bank plus ALU. Operand A is always R[rd];
// operand B is either R[rs] or an externally supplied value (immediate or
// data-memory word). The result is written back to rd.
//   clk, rst : clock, async active-high reset
//   reg_we   : write result to R[rd] this edge
//   rd_idx   : destination / operand A register
//   rs_idx   : operand B register
//   alu_op   : ALU operation
//   use_imm  : take operand B from imm_data instead of R[rs]
//   imm_data : immediate or loaded value
//   rd_val   : current R[rd] (for ST and BEQZ)
module simple_cpu_execunit
  import simple_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] rd_idx,
  input  logic [REG_AW-1:0] rs_idx,
  input  alu_op_e           alu_op,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm_data,
  output logic [DATA_W-1:0] rd_val
);

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;

  simple_cpu_regbank RegBank (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rd_idx),
    .ra_data (rd_val),
    .rb_addr (rs_idx),
    .rb_data (rs_val),
    .we      (reg_we),
    .wa      (rd_idx),
    .wd      (result)
  );

  always_comb begin
    op_b   = use_imm ? imm_data : rs_val;
    result = op_b;
    case (alu_op)
      ALU_PASS_B: result = op_b;
      ALU_ADD:    result = rd_val + op_b;
      ALU_SUB:    result = rd_val - op_b;
      ALU_AND:    result = rd_val & op_b;
      ALU_OR:     result = rd_val | op_b;
      ALU_XOR:    result = rd_val ^ op_b;
      default:    result = op_b;
    endcase
  end

endmodule

// File: rtl/simple_cpu_imem.sv
// simple_cpu_imem: 1024x16 instruction memory, read-only to the core.
// Every word starts as HALT; contents are preloaded hierarchically.
//   addr  : instruction address (pc)
//   rdata : instruction word, combinational read
module simple_cpu_imem
  import simple_cpu_pkg::*;
(
  input  logic [PC_W-1:0]   addr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_array [0:IMEM_DEPTH-1] = '{default: HALT_WORD};

  assign rdata = mem_array[addr];

endmodule

// File: rtl/simple_cpu_regbank.sv
// simple_cpu_regbank: 16x16 register file, two async read ports, one
// synchronous write port, all registers cleared by reset.
//   clk, rst       : clock, async active-high reset
//   ra_addr/ra_data: read port A
//   rb_addr/rb_data: read port B
//   we, wa, wd     : write enable, address, data
module simple_cpu_regbank
  import simple_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem [0:NREGS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/simple_cpu.sv
// simple_cpu: single-cycle 16-bit accumulator-style core. Fetch and data
// reads are combinational; register, data-memory and pc updates share one
// rising edge. HALT holds the pc until reset.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset (pc and registers to 0)
//   pc  : address of the instruction currently executing
module simple_cpu
  import simple_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] dmem_rdata;
  instr_t            instr;
  logic [DATA_W-1:0] rd_val;

  logic              reg_we;
  logic              st_op;
  logic              dmem_we;
  alu_op_e           alu_op;
  logic              use_imm;
  logic [DATA_W-1:0] imm_data;

  simple_cpu_imem instmem (
    .addr  (pc_q),
    .rdata (imem_rdata)
  );

  assign instr = instr_t'(imem_rdata);

  simple_cpu_dmem datamemory (
    .clk   (clk),
    .we    (dmem_we),
    .addr  (instr.imm8),
    .wdata (rd_val),
    .rdata (dmem_rdata)
  );

  simple_cpu_execunit execunit (
    .clk      (clk),
    .rst      (rst),
    .reg_we   (reg_we),
    .rd_idx   (instr.rd),
    .rs_idx   (instr.imm8[3:0]),
    .alu_op   (alu_op),
    .use_imm  (use_imm),
    .imm_data (imm_data),
    .rd_val   (rd_val)
  );

  // Data memory has no reset of its own, so stores are suppressed here
  // while reset is held.
  assign dmem_we = st_op & ~rst;

  always_comb begin
    reg_we   = 1'b0;
    st_op    = 1'b0;
    alu_op   = ALU_PASS_B;
    use_imm  = 1'b1;
    imm_data = zext8(instr.imm8);
    pc_d     = pc_q + PC_W'(1);
    case (instr.opcode)
      OP_LD: begin
        reg_we   = 1'b1;
        imm_data = dmem_rdata;
      end
      OP_JMP:  pc_d = PC_W'(instr.imm8);
      OP_ADD: begin
        reg_we  = 1'b1;
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
      end
      OP_LDI:  reg_we = 1'b1;
      OP_SUB: begin
        reg_we  = 1'b1;
        alu_op  = ALU_SUB;
        use_imm = 1'b0;
      end
      OP_ST:   st_op = 1'b1;
      OP_BEQZ: begin
        if (rd_val == '0) begin
          pc_d = PC_W'(instr.imm8);
        end
      end
      OP_ADDI: begin
        reg_we = 1'b1;
        alu_op = ALU_ADD;
      end
      OP_AND: begin
        reg_we  = 1'b1;
        alu_op  = ALU_AND;
        use_imm = 1'b0;
      end
      OP_OR: begin
        reg_we  = 1'b1;
        alu_op  = ALU_OR;
        use_imm = 1'b0;
      end
      OP_XOR: begin
        reg_we  = 1'b1;
        alu_op  = ALU_XOR;
        use_imm = 1'b0;
      end
      OP_HALT: pc_d = pc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_simple_cpu.sv
// tb_simple_cpu: directed test of the SimpleCPU core with hand-computed
// expected values; memories and registers are preloaded and inspected
// through the hierarchy.
module tb_simple_cpu;

  logic       clk;
  logic       rst;
  logic [9:0] pc;

  int total = 0;
  int bad   = 0;

  logic [15:0] dshadow [0:255];
  logic [15:0] d4;

  simple_cpu dut (
    .clk (clk),
    .rst (rst),
    .pc  (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.instmem.mem_array[i] = 16'hF000;
  endtask

  task automatic load_ref_prog();
    clear_imem();
    dut.instmem.mem_array[0] = 16'h3000;
    dut.instmem.mem_array[1] = 16'h3101;
    dut.instmem.mem_array[2] = 16'h0204;
    dut.instmem.mem_array[3] = 16'h5205;
    dut.instmem.mem_array[4] = 16'h0205;
    dut.instmem.mem_array[5] = 16'h5208;
    dut.instmem.mem_array[6] = 16'h1009;
  endtask

  task automatic randomize_dmem();
    for (int i = 0; i < 256; i++) begin
      dshadow[i] = {8'h00, 8'($urandom_range(255, 0))};
      dut.datamemory.mem_array[i] = dshadow[i];
    end
    d4 = dshadow[4];
  endtask

  // Assert reset, hold it across one edge, release just after that edge.
  task automatic start_reset();
    rst = 1'b1;
    #1;
  endtask

  task automatic finish_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #1;
    load_ref_prog();
    randomize_dmem();
    #10;
    rst = 1'b0;

    // Reset state at 11 ns
    check("reset_pc", 16'(pc), 16'h0000);
    for (int i = 0; i < 16; i++)
      check($sformatf("reset_r%0d", i), dut.execunit.RegBank.mem[i], 16'h0000);

    // Reference program
    tick();
    check("ref_pc1", 16'(pc), 16'h0001);
    check("ref_r0", dut.execunit.RegBank.mem[0], 16'h0000);
    tick();
    check("ref_pc2", 16'(pc), 16'h0002);
    check("ref_r1", dut.execunit.RegBank.mem[1], 16'h0001);
    tick();
    check("ref_ld_r2", dut.execunit.RegBank.mem[2], d4);
    tick();
    tick();
    tick();
    tick();
    check("ref_pc_after7", 16'(pc), 16'h0009);
    tick();
    tick();
    tick();
    check("ref_pc_halt", 16'(pc), 16'h0009);
    check("ref_final_r0", dut.execunit.RegBank.mem[0], 16'h0000);
    check("ref_final_r1", dut.execunit.RegBank.mem[1], 16'h0001);
    check("ref_final_r2", dut.execunit.RegBank.mem[2], d4);
    dshadow[5] = d4;
    dshadow[8] = d4;
    for (int i = 0; i < 256; i++)
      check($sformatf("ref_dmem%0d", i), dut.datamemory.mem_array[i], dshadow[i]);

    // Arithmetic, logic ops, wrap and NOP
    start_reset();
    clear_imem();
    dut.instmem.mem_array[0]  = 16'h31FF; // LDI r1,FF
    dut.instmem.mem_array[1]  = 16'h71FF; // ADDI r1,FF  -> 01FE
    dut.instmem.mem_array[2]  = 16'h2101; // ADD r1,r1   -> 03FC
    dut.instmem.mem_array[3]  = 16'h4201; // SUB r2,r1   -> FC04
    dut.instmem.mem_array[4]  = 16'h3355; // LDI r3,55
    dut.instmem.mem_array[5]  = 16'h340F; // LDI r4,0F
    dut.instmem.mem_array[6]  = 16'h8304; // AND r3,r4   -> 0005
    dut.instmem.mem_array[7]  = 16'h9301; // OR  r3,r1   -> 03FD
    dut.instmem.mem_array[8]  = 16'hA302; // XOR r3,r2   -> FFF9
    dut.instmem.mem_array[9]  = 16'h2303; // ADD r3,r3   -> FFF2
    dut.instmem.mem_array[10] = 16'hC123; // NOP
    finish_reset();
    tick();
    tick();
    check("arith_addi", dut.execunit.RegBank.mem[1], 16'h01FE);
    tick();
    check("arith_add", dut.execunit.RegBank.mem[1], 16'h03FC);
    tick();
    check("arith_sub_wrap", dut.execunit.RegBank.mem[2], 16'hFC04);
    tick();
    tick();
    tick();
    check("logic_and", dut.execunit.RegBank.mem[3], 16'h0005);
    tick();
    check("logic_or", dut.execunit.RegBank.mem[3], 16'h03FD);
    tick();
    check("logic_xor", dut.execunit.RegBank.mem[3], 16'hFFF9);
    tick();
    check("arith_add_wrap", dut.execunit.RegBank.mem[3], 16'hFFF2);
    tick();
    tick();
    tick();
    check("nop_halt_pc", 16'(pc), 16'h000B);
    check("nop_r1", dut.execunit.RegBank.mem[1], 16'h03FC);

    // Branch
    start_reset();
    clear_imem();
    dut.instmem.mem_array[0] = 16'h3301; // LDI r3,1
    dut.instmem.mem_array[1] = 16'h6320; // BEQZ r3,20 (not taken)
    dut.instmem.mem_array[2] = 16'h3300; // LDI r3,0
    dut.instmem.mem_array[3] = 16'h6320; // BEQZ r3,20 (taken)
    finish_reset();
    tick();
    tick();
    check("beqz_not_taken", 16'(pc), 16'h0002);
    tick();
    tick();
    check("beqz_taken", 16'(pc), 16'h0020);
    tick();
    check("beqz_halt", 16'(pc), 16'h0020);

    // pc wrap 1023 -> 0
    start_reset();
    clear_imem();
    dut.instmem.mem_array[0] = 16'h10FE; // JMP FE
    for (int i = 254; i < 1023; i++) dut.instmem.mem_array[i] = 16'h3507;
    dut.instmem.mem_array[1023] = 16'h3509;
    finish_reset();
    tick();
    check("wrap_jmp", 16'(pc), 16'h00FE);
    for (int i = 0; i < 769; i++) tick();
    check("wrap_pc1023", 16'(pc), 16'h03FF);
    check("wrap_r5_pre", dut.execunit.RegBank.mem[5], 16'h0007);
    tick();
    check("wrap_pc0", 16'(pc), 16'h0000);
    check("wrap_r5", dut.execunit.RegBank.mem[5], 16'h0009);
    tick();
    check("wrap_rejmp", 16'(pc), 16'h00FE);

    // Mid-run reset during the reference program
    start_reset();
    load_ref_prog();
    randomize_dmem();
    dshadow[7] = 16'h00A5;
    dut.datamemory.mem_array[7] = 16'h00A5;
    finish_reset();
    tick();
    tick();
    tick();
    tick();
    check("mid_pc4", 16'(pc), 16'h0004);
    check("mid_dmem5_written", dut.datamemory.mem_array[5], d4);
    rst = 1'b1;
    #1;
    check("mid_pc_async", 16'(pc), 16'h0000);
    check("mid_r1_clear", dut.execunit.RegBank.mem[1], 16'h0000);
    check("mid_r2_clear", dut.execunit.RegBank.mem[2], 16'h0000);
    // A store at address 0 must not fire while reset is held.
    dut.instmem.mem_array[0] = 16'h5F07;
    tick();
    check("mid_pc_held", 16'(pc), 16'h0000);
    check("mid_no_store", dut.datamemory.mem_array[7], 16'h00A5);
    check("mid_dmem5_kept", dut.datamemory.mem_array[5], d4);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
